// File: rtl/axi4_arb_pkg.sv
// Shared types and helpers for the crossbar's per-slave write/read arbiters.
package axi4_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_MASTERS = 32;

  // OR-ing the positions of set bits yields the binary index for a one-hot input.
  function automatic int unsigned onehot_to_idx(input logic [MAX_MASTERS-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (onehot[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker
  import axi4_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] pick,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_MASTERS)) sum = sum - (IDX_W + 1)'(NUM_MASTERS);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        pick[cand] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign idx = IDX_W'(onehot_to_idx(MAX_MASTERS'(pick)));
  assign any = |req;

endmodule

// File: rtl/axi4_slave_write_arbiter.sv
// Per-slave-port AW/W arbiter: holds a round-robin grant until both AW and WLAST complete.
module axi4_slave_write_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   s_awvalid,
  input  logic                   s_awready,
  input  logic                   s_wvalid,
  input  logic                   s_wready,
  input  logic                   s_wlast,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid,
  output logic                   aw_open,
  output logic                   w_open
);

  arb_state_t             state_reg, state_next;
  logic [IDX_W-1:0]       ptr_reg, ptr_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic                   valid_reg, valid_next;
  logic                   aw_open_reg, aw_open_next;
  logic                   w_open_reg, w_open_next;
  logic                   aw_done_reg, aw_done_next;
  logic                   w_done_reg, w_done_next;

  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   aw_hs, w_hs;

  rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req (req),
    .ptr (ptr_reg),
    .pick(pick),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Handshakes only count on an open path, so IDLE and post-completion beats are ignored.
  assign aw_hs = s_awvalid & s_awready & aw_open_reg;
  assign w_hs  = s_wvalid & s_wready & s_wlast & w_open_reg;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    grant_next   = grant_reg;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    aw_open_next = aw_open_reg;
    w_open_next  = w_open_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next   = BUSY;
          grant_next   = pick;
          idx_next     = pick_idx;
          valid_next   = 1'b1;
          aw_open_next = 1'b1;
          w_open_next  = 1'b1;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          ptr_next     = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      BUSY: begin
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg | w_hs;
        aw_open_next = aw_open_reg & ~aw_hs;
        w_open_next  = w_open_reg & ~w_hs;
        if (aw_done_next && w_done_next) begin
          state_next   = IDLE;
          grant_next   = '0;
          idx_next     = '0;
          valid_next   = 1'b0;
          aw_open_next = 1'b0;
          w_open_next  = 1'b0;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      grant_reg   <= '0;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      aw_open_reg <= 1'b0;
      w_open_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      grant_reg   <= grant_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      aw_open_reg <= aw_open_next;
      w_open_reg  <= w_open_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_idx   = idx_reg;
  assign grant_valid = valid_reg;
  assign aw_open     = aw_open_reg;
  assign w_open      = w_open_reg;

endmodule

// File: tb/tb_axi4_slave_write_arbiter.sv
// Directed bench for axi4_slave_write_arbiter with a per-cycle ownership model.
module tb_axi4_slave_write_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid, aw_open, w_open;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  // Model: who owns the slave port and which halves of the burst are finished.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  bit m_aw_done = 1'b0;
  bit m_w_done = 1'b0;

  axi4_slave_write_arbiter #(.NUM_MASTERS(N), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .s_awvalid  (s_awvalid),
    .s_awready  (s_awready),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_wlast    (s_wlast),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .aw_open    (aw_open),
    .w_open     (w_open)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_aw_done = 1'b0; m_w_done = 1'b0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && req[(m_ptr + k) % N]) begin
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % N;
        end
      end
      if (m_busy) begin
        m_ptr = (m_owner + 1) % N;
        m_aw_done = 1'b0;
        m_w_done = 1'b0;
      end
    end else begin
      if (s_awvalid && s_awready) m_aw_done = 1'b1;
      if (s_wvalid && s_wready && s_wlast) m_w_done = 1'b1;
      if (m_aw_done && m_w_done) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0]  e_grant;
    logic [IW-1:0] e_idx;
    logic          e_valid, e_aw, e_w;
    if (chk_en) begin
      e_grant = m_busy ? N'(1 << m_owner) : '0;
      e_idx   = m_busy ? IW'(m_owner) : '0;
      e_valid = m_busy;
      e_aw    = m_busy && !m_aw_done;
      e_w     = m_busy && !m_w_done;
      total++;
      if (grant !== e_grant || grant_idx !== e_idx || grant_valid !== e_valid ||
          aw_open !== e_aw || w_open !== e_w) begin
        bad++;
        $display("FAIL model_cycle%0d: got grant=%b idx=%0d valid=%b aw=%b w=%b expected grant=%b idx=%0d valid=%b aw=%b w=%b",
                 cyc, grant, grant_idx, grant_valid, aw_open, w_open,
                 e_grant, e_idx, e_valid, e_aw, e_w);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic hs(input logic aw, input logic w, input logic last);
    s_awvalid = aw; s_awready = aw;
    s_wvalid = w; s_wready = w; s_wlast = last;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok %s = %0d", name, act);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; hs(0, 0, 0);
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;
    chk("reset_grant", 32'(grant), 0);
    chk("reset_valid", 32'(grant_valid), 0);

    // Single request, pointer advances past the winner
    req = 4'b0100; tick(); req = '0;
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_idx", 32'(grant_idx), 2);
    chk("t1_aw_open", 32'(aw_open), 1);
    chk("t1_w_open", 32'(w_open), 1);
    chk("t1_model_ptr", 32'(m_ptr), 3);
    hs(1, 1, 1); tick(); hs(0, 0, 0);
    chk("t1_release", 32'(grant_valid), 0);

    // AW first, then 4-beat W; repeated AW on the closed path is ignored
    req = 4'b0010; tick(); req = '0;
    chk("t2_idx", 32'(grant_idx), 1);
    tick();
    hs(1, 0, 0); tick();
    chk("t2_aw_closed", 32'(aw_open), 0);
    chk("t2_w_still_open", 32'(w_open), 1);
    for (int b = 0; b < 4; b++) begin
      hs(1, 1, (b == 3)); tick();
      if (b < 3) chk("t2_mid_burst_valid", 32'(grant_valid), 1);
    end
    hs(0, 0, 0);
    chk("t2_release", 32'(grant_valid), 0);

    // W completes before AW
    req = 4'b0001; tick(); req = '0;
    chk("t3_idx", 32'(grant_idx), 0);
    hs(0, 1, 1); tick(); hs(0, 0, 0);
    chk("t3_w_closed", 32'(w_open), 0);
    chk("t3_aw_open", 32'(aw_open), 1);
    tick(); tick();
    chk("t3_held", 32'(grant_valid), 1);
    hs(1, 0, 0); tick(); hs(0, 0, 0);
    chk("t3_release", 32'(grant_valid), 0);

    // Handshakes in IDLE do nothing
    hs(1, 1, 1); tick(); hs(0, 0, 0);
    chk("idle_hs_ignored", 32'(grant_valid), 0);

    // Fair rotation with one idle cycle between grants
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("t4_rotation_idx", 32'(grant_idx), 32'(g % 4));
      hs(1, 1, 1); tick(); hs(0, 0, 0);
      if (g == 4) req = '0;
      chk("t4_gap_idle", 32'(grant_valid), 0);
    end
    tick();
    chk("t4_stays_idle", 32'(grant_valid), 0);

    // Wrap-around from pointer 3
    req = 4'b0100; tick();
    chk("t5_first_idx", 32'(grant_idx), 2);
    hs(1, 1, 1); tick(); hs(0, 0, 0);
    req = 4'b1001; tick();
    chk("t5_wrap_idx3", 32'(grant_idx), 3);
    hs(1, 1, 1); tick(); hs(0, 0, 0); tick();
    chk("t5_wrap_idx0", 32'(grant_idx), 0);
    req = '0; hs(1, 1, 1); tick(); hs(0, 0, 0);
    chk("t5_release", 32'(grant_valid), 0);

    // Reset while BUSY abandons the burst and clears the pointer
    req = 4'b0100; tick(); req = '0;
    hs(1, 0, 0); tick(); hs(0, 0, 0);
    chk("t6_w_open_before_rst", 32'(w_open), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_valid", 32'(grant_valid), 0);
    chk("t6_model_ptr", 32'(m_ptr), 0);
    req = 4'b0010; tick(); req = '0;
    chk("t6_regrant", 32'(grant), 32'h2);
    chk("t6_regrant_idx", 32'(grant_idx), 1);
    hs(1, 1, 1); tick(); hs(0, 0, 0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_slave_write_arbiter.md
Name: axi4_slave_write_arbiter

Overview:
- Per-slave-port write arbiter for the AXI4 crossbar. One instance sits in front of each slave port.
- Selects one master whose AW request decodes to this slave and drives the select lines of the crossbar's AW/W muxes.
- Holds the grant until both the AW handshake and the final W beat (WLAST) have completed on the slave side, then re-arbitrates round-robin.
- Does not carry payload. It only observes handshakes. B/R routing is handled elsewhere by ID prefix.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (>=2).
- IDX_W, $clog2(NUM_MASTERS), width of the grant index.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- req  input  NUM_MASTERS  bit i = master i AWVALID with address decoded to this slave.
- s_awvalid  input  1  muxed AWVALID seen at slave port.
- s_awready  input  1  slave AWREADY.
- s_wvalid  input  1  muxed WVALID at slave port.
- s_wready  input  1  slave WREADY.
- s_wlast  input  1  muxed WLAST at slave port.
- grant  output  NUM_MASTERS  one-hot select for AW/W mux; all-zero when idle.
- grant_idx  output  IDX_W  binary index of granted master; 0 when idle.
- grant_valid  output  1  a grant is held.
- aw_open  output  1  AW path enabled (grant held, AW not yet handshaken).
- w_open  output  1  W path enabled (grant held, WLAST not yet handshaken).

Behaviour:
- All outputs are registered. On reset: grant=0, grant_idx=0, grant_valid=0, aw_open=0, w_open=0, state=IDLE, rr pointer=0, aw_done=0, w_done=0.
- States: IDLE, BUSY.
- IDLE, req!=0 in cycle t:
  - pick the first set bit searching from ptr upward with wrap-around (ptr, ptr+1, ..., NUM_MASTERS-1, 0, ..., ptr-1);
  - at t+1: state=BUSY, grant/grant_idx/grant_valid set, aw_open=1, w_open=1, aw_done=w_done=0;
  - ptr <= picked+1, modulo NUM_MASTERS (NUM_MASTERS-1 wraps to 0).
- IDLE, req==0: stay IDLE, outputs unchanged at idle values.
- BUSY:
  - AW handshake (s_awvalid&&s_awready&&aw_open) sets aw_done and clears aw_open next cycle.
  - W last handshake (s_wvalid&&s_wready&&s_wlast&&w_open) sets w_done and clears w_open next cycle.
  - Non-last W beats do not change state.
- W may complete before AW (AXI4 permits W ahead of AW). Either order releases correctly. Both events in the same cycle are also legal.
- Release: when aw_done and w_done are both true (counting the current cycle's events), the next cycle is IDLE with all grant outputs 0. Re-arbitration in that IDLE cycle produces a new grant one cycle later. Minimum gap between grants is 1 idle cycle.
- Requests are ignored while BUSY. Deassertion of the granted req mid-transaction does not release the grant; only the handshakes release it.
- Handshakes observed while in IDLE, or on a closed path, are ignored.
- rst asserted mid-BUSY: next cycle all outputs return to reset values and ptr=0. An in-flight burst is abandoned; the crossbar-level reset covers the slave.
- Fairness: with all masters requesting continuously, grants rotate 0,1,2,3,0,...

Decomposition:
- Package axi4_arb_pkg: state enum (IDLE, BUSY) and a helper function for one-hot-to-index.
- One combinational sub-module, rr_picker (req, ptr -> one-hot pick, index, any). It is reused later by the read-channel arbiter.

Test Plan:
1. Reset, then req=4'b0100 at t: grant=4'b0100, grant_idx=2, aw_open=w_open=1 at t+1; ptr=3.
2. Granted master 1; AW handshake at cycle 3, 4-beat W with WLAST at cycle 7: aw_open drops at 4, w_open drops at 8, grant_valid=0 at 8.
3. W-before-AW: WLAST handshake at cycle 2, AW handshake at cycle 5 -> release at cycle 6, grant held through cycle 5.
4. req=4'b1111 held, single-beat bursts, AW and WLAST in the same cycle each time: grant_idx sequence 0,1,2,3,0 with exactly one idle cycle between grants.
5. ptr=3 after a grant to 2, req=4'b1001: wrap picks master 3, then master 0 next.
6. rst pulsed while BUSY with w_open=1: next cycle grant=0, grant_valid=0, state IDLE, ptr=0; a subsequent req=4'b0010 grants master 1.
